// File: rtl/full_adder_pkg.sv
// rtl/full_adder_pkg.sv - shared latency constant and reference sum for the registered full adder
package full_adder_pkg;

   localparam int FA_LATENCY   = 2;
   localparam int FA_MAX_WIDTH = 64;

   // Zero-extended operands: bits [WIDTH:0] of the result give {carry_out, sum} for any WIDTH.
   function automatic logic [FA_MAX_WIDTH:0] fa_ref(input logic [FA_MAX_WIDTH-1:0] a,
                                                    input logic [FA_MAX_WIDTH-1:0] b,
                                                    input logic                    ci);
      return {1'b0, a} + {1'b0, b} + {{FA_MAX_WIDTH{1'b0}}, ci};
   endfunction

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - combinational 1-bit full adder cell
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic p;

   assign p  = a ^ b;
   assign s  = p ^ ci;
   assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder_reg.sv
// rtl/full_adder_reg.sv - two-stage registered ripple-carry adder
module full_adder_reg
   import full_adder_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             ci_q;
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         a_q  <= '0;
         b_q  <= '0;
         ci_q <= 1'b0;
      end else begin
         a_q  <= a;
         b_q  <= b;
         ci_q <= carry_in;
      end
   end

   assign carry[0] = ci_q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      fa_cell u_cell (
         .a  (a_q[i]),
         .b  (b_q[i]),
         .ci (carry[i]),
         .s  (sum_d[i]),
         .co (carry[i+1])
      );
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sum       <= '0;
         carry_out <= 1'b0;
      end else begin
         sum       <= sum_d;
         carry_out <= carry[WIDTH];
      end
   end

`ifdef FORMAL
   // History of inputs and reset, aligned so *_d2 matches what the outputs currently show.
   logic                  past_valid_1 = 1'b0;
   logic                  past_valid_2 = 1'b0;
   logic                  rst_d1;
   logic                  rst_d2;
   logic [WIDTH-1:0]      a_d1, a_d2, b_d1, b_d2;
   logic                  ci_d1, ci_d2;
   logic [FA_MAX_WIDTH:0] ref_d2;

   always_ff @(posedge clk) begin
      past_valid_1 <= 1'b1;
      past_valid_2 <= past_valid_1;
      rst_d1       <= !rstn;
      rst_d2       <= rst_d1;
      a_d1         <= a;
      a_d2         <= a_d1;
      b_d1         <= b;
      b_d2         <= b_d1;
      ci_d1        <= carry_in;
      ci_d2        <= ci_d1;
   end

   assign ref_d2 = fa_ref(FA_MAX_WIDTH'(a_d2), FA_MAX_WIDTH'(b_d2), ci_d2);

   always_comb begin
      if (!past_valid_1) assume (!rstn);
      if (past_valid_2) begin
         if (!rstn || rst_d1 || rst_d2)
            assert ({carry_out, sum} == '0);
         else
            assert ({carry_out, sum} == ref_d2[WIDTH:0]);
      end
      cover (carry_out);
      cover (sum == '1);
   end

   localparam int LATENCY_CHECK = FA_LATENCY;
`endif

endmodule

// File: tb/tb_full_adder_reg.sv
// tb/tb_full_adder_reg.sv - randomized self-checking bench for full_adder_reg at widths 1, 8 and 16
module tb_full_adder_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic        a1, b1, ci1, s1, co1;
   logic [7:0]  a8, b8, s8;
   logic        ci8, co8;
   logic [15:0] a16, b16, s16;
   logic        ci16, co16;

   int checks = 0;
   int errors = 0;

   // Results of operand sets accepted at clock edges since the last reset, oldest first.
   logic [1:0]  q1[$];
   logic [8:0]  q8[$];
   logic [16:0] q16[$];

   full_adder_reg #(.WIDTH(1)) u_w1 (
      .clk(clk), .rstn(rstn), .a(a1), .b(b1), .carry_in(ci1), .sum(s1), .carry_out(co1)
   );
   full_adder_reg #(.WIDTH(8)) u_w8 (
      .clk(clk), .rstn(rstn), .a(a8), .b(b8), .carry_in(ci8), .sum(s8), .carry_out(co8)
   );
   full_adder_reg #(.WIDTH(16)) u_w16 (
      .clk(clk), .rstn(rstn), .a(a16), .b(b16), .carry_in(ci16), .sum(s16), .carry_out(co16)
   );

   // Output after an edge is the arithmetic result of the set accepted one edge earlier.
   function automatic logic [1:0] exp1();
      return (q1.size() >= 2) ? q1[q1.size()-2] : 2'b0;
   endfunction
   function automatic logic [8:0] exp8();
      return (q8.size() >= 2) ? q8[q8.size()-2] : 9'b0;
   endfunction
   function automatic logic [16:0] exp16();
      return (q16.size() >= 2) ? q16[q16.size()-2] : 17'b0;
   endfunction

   task automatic clear_model();
      q1.delete();
      q8.delete();
      q16.delete();
   endtask

   task automatic rand_inputs();
      a1 = 1'($urandom);  b1 = 1'($urandom);  ci1 = 1'($urandom);
      a8 = 8'($urandom);  b8 = 8'($urandom);  ci8 = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom);
   endtask

   task automatic tick();
      if (rstn) begin
         q1.push_back(2'(a1) + 2'(b1) + 2'(ci1));
         q8.push_back(9'(a8) + 9'(b8) + 9'(ci8));
         q16.push_back(17'(a16) + 17'(b16) + 17'(ci16));
      end
      @(posedge clk);
      #1;
      while (q1.size() > 2) void'(q1.pop_front());
      while (q8.size() > 2) void'(q8.pop_front());
      while (q16.size() > 2) void'(q16.pop_front());
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      clear_model();
      a1 = 1'b0; b1 = 1'b1; ci1 = 1'b1;
      a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
      a16 = 16'hFFFF; b16 = 16'hFFFF; ci16 = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
         #3;
         checks++;
         if ({co1, s1} !== 2'b0 || {co8, s8} !== 9'b0 || {co16, s16} !== 17'b0) begin
            errors++;
            $display("FAIL reset_midcycle: got w1=%h w8=%h w16=%h want 0", {co1, s1}, {co8, s8}, {co16, s16});
         end
         tick();
         checks++;
         if ({co1, s1} !== 2'b0 || {co8, s8} !== 9'b0 || {co16, s16} !== 17'b0) begin
            errors++;
            $display("FAIL reset_edge: got w1=%h w8=%h w16=%h want 0", {co1, s1}, {co8, s8}, {co16, s16});
         end
      end
   endtask

   task automatic test_exhaustive_1bit();
      rstn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         rand_inputs();
         if (i < 8) {a1, b1, ci1} = 3'(i);
         tick();
         checks++;
         if ({co1, s1} !== exp1()) begin
            errors++;
            $display("FAIL exhaustive_w1 step %0d: got %h want %h", i, {co1, s1}, exp1());
         end
         checks++;
         if ({co8, s8} !== exp8() || {co16, s16} !== exp16()) begin
            errors++;
            $display("FAIL exhaustive_wide step %0d: got %h/%h want %h/%h", i, {co8, s8}, {co16, s16}, exp8(), exp16());
         end
      end
   endtask

   task automatic test_boundaries();
      rstn = 1'b1;
      a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
      a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
      a16 = 16'hFFFF; b16 = 16'hFFFF; ci16 = 1'b1;
      tick();
      a1 = 1'b1; b1 = 1'b0; ci1 = 1'b1;
      a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b1;
      a16 = 16'hFFFF; b16 = 16'h0000; ci16 = 1'b1;
      tick();
      checks++;
      if ({co1, s1} !== 2'b11 || {co8, s8} !== 9'h1FF || {co16, s16} !== 17'h1FFFF) begin
         errors++;
         $display("FAIL all_ones_plus_one: got %h/%h/%h want 3/1ff/1ffff", {co1, s1}, {co8, s8}, {co16, s16});
      end
      a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
      a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0;
      a16 = 16'h0000; b16 = 16'h0000; ci16 = 1'b0;
      tick();
      checks++;
      if ({co1, s1} !== 2'b10 || {co8, s8} !== 9'h100 || {co16, s16} !== 17'h10000) begin
         errors++;
         $display("FAIL wrap_to_zero: got %h/%h/%h want 2/100/10000", {co1, s1}, {co8, s8}, {co16, s16});
      end
      rand_inputs();
      tick();
      checks++;
      if ({co1, s1} !== 2'b00 || {co8, s8} !== 9'h000 || {co16, s16} !== 17'h00000) begin
         errors++;
         $display("FAIL all_zeros: got %h/%h/%h want 0/0/0", {co1, s1}, {co8, s8}, {co16, s16});
      end
   endtask

   task automatic test_back_to_back(input int n);
      rstn = 1'b1;
      for (int i = 0; i < n; i++) begin
         rand_inputs();
         tick();
         checks++;
         if ({co1, s1} !== exp1() || {co8, s8} !== exp8() || {co16, s16} !== exp16()) begin
            errors++;
            $display("FAIL stream cycle %0d: got %h/%h/%h want %h/%h/%h", i,
                     {co1, s1}, {co8, s8}, {co16, s16}, exp1(), exp8(), exp16());
         end
      end
   endtask

   task automatic test_mid_reset();
      rstn = 1'b1;
      a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
      a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1;
      a16 = 16'h8000; b16 = 16'h8000; ci16 = 1'b0;
      tick();
      rand_inputs();
      tick();
      checks++;
      if ({co1, s1} !== 2'b11 || {co8, s8} !== 9'h047 || {co16, s16} !== 17'h10000) begin
         errors++;
         $display("FAIL pre_reset_result: got %h/%h/%h want 3/047/10000", {co1, s1}, {co8, s8}, {co16, s16});
      end
      #2;
      rstn = 1'b0;
      clear_model();
      #1;
      checks++;
      if ({co1, s1} !== 2'b0 || {co8, s8} !== 9'b0 || {co16, s16} !== 17'b0) begin
         errors++;
         $display("FAIL async_clear: got %h/%h/%h want 0", {co1, s1}, {co8, s8}, {co16, s16});
      end
      tick();
      rstn = 1'b1;
      a1 = 1'b1; b1 = 1'b0; ci1 = 1'b0;
      a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0;
      a16 = 16'h0001; b16 = 16'h0002; ci16 = 1'b1;
      tick();
      checks++;
      if ({co1, s1} !== 2'b0 || {co8, s8} !== 9'b0 || {co16, s16} !== 17'b0) begin
         errors++;
         $display("FAIL first_edge_after_release: got %h/%h/%h want 0", {co1, s1}, {co8, s8}, {co16, s16});
      end
      rand_inputs();
      tick();
      checks++;
      if ({co1, s1} !== 2'b01 || {co8, s8} !== 9'h100 || {co16, s16} !== 17'h00004) begin
         errors++;
         $display("FAIL second_edge_after_release: got %h/%h/%h want 1/100/00004", {co1, s1}, {co8, s8}, {co16, s16});
      end
   endtask

   initial begin
      rstn = 1'b0;
      a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
      a8 = '0; b8 = '0; ci8 = 1'b0;
      a16 = '0; b16 = '0; ci16 = 1'b0;
      test_reset();
      test_exhaustive_1bit();
      test_boundaries();
      test_back_to_back(200);
      test_mid_reset();
      test_back_to_back(10000);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
